// File: rtl/sdio_bus_pkg.sv
// Shared definitions for the SDIO host DMA bus slave memory.
//   - bus widths (BUS_AW address bits, BUS_DW data bits)
//   - FSM state encodings and the state_t enum built from them
//   - STAT_W, the width of the optional access counters
package sdio_bus_pkg;

  localparam int BUS_AW = 17;
  localparam int BUS_DW = 8;
  localparam int STAT_W = 16;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_WAIT_ENC = 3'd1;
  localparam logic [2:0] ST_ACK_ENC  = 3'd2;
  localparam logic [2:0] ST_RLAT_ENC = 3'd3;
  localparam logic [2:0] ST_BD_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_ACK  = ST_ACK_ENC,
    ST_RLAT = ST_RLAT_ENC,
    ST_BD   = ST_BD_ENC
  } state_t;

endpackage

// File: rtl/sdio_bus_ram.sv
// Single-port synchronous byte RAM, DEPTH x 8, with a 1-cycle registered read.
// Ports:
//   clk    clock
//   en     port enable (read when we=0, write when we=1)
//   we     write enable
//   addr   byte address
//   wdata  write byte
//   rdata  read byte; updated only by reads, held otherwise
// Contents and rdata are not reset.
module sdio_bus_ram
  import sdio_bus_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BUS_DW-1:0] wdata,
  output logic [BUS_DW-1:0] rdata
);

  logic [BUS_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/sdio_bus_mem.sv
// Byte-wide bus slave memory behind the SDIO host DMA master, with programmable
// wait states, programmable read latency and a backdoor port for preload/dump.
// Ports:
//   bus_clk, rst                  clock, asynchronous active-high reset
//   bus_rd/bus_wr/bus_addr/bus_wdata   held request from the DMA master
//   bus_ready                     1-cycle pulse: request accepted
//   bus_rdata_ready, bus_rdata    1-cycle read-valid pulse, held read byte
//   bd_req/bd_we/bd_addr/bd_wdata backdoor access
//   bd_ack, bd_rdata              1-cycle backdoor done pulse, read byte
//   proto_err                     sticky: rd and wr seen together
//   stat_wr_cnt, stat_rd_cnt      saturating accepted-access counters,
//                                 present only with SDIO_BUS_STAT_EN defined
//
// state | meaning
// IDLE  | sample bus request (priority) or backdoor request
// WAIT  | wait-state down-counter running on latched request
// ACK   | bus_ready high; write commits to RAM here
// RLAT  | read latency down-counter; bus_rdata_ready at terminal count
// BD    | backdoor access in flight; bd_ack follows
module sdio_bus_mem
  import sdio_bus_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int WAIT_CYC  = 0,
  parameter int RD_LAT    = 1
) (
  input  logic                         bus_clk,
  input  logic                         rst,
  input  logic                         bus_rd,
  input  logic                         bus_wr,
  input  logic [BUS_AW-1:0]            bus_addr,
  input  logic [BUS_DW-1:0]            bus_wdata,
  output logic                         bus_ready,
  output logic                         bus_rdata_ready,
  output logic [BUS_DW-1:0]            bus_rdata,
  input  logic                         bd_req,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [BUS_DW-1:0]            bd_wdata,
  output logic                         bd_ack,
  output logic [BUS_DW-1:0]            bd_rdata,
  output logic                         proto_err
`ifdef SDIO_BUS_STAT_EN
  ,
  output logic [STAT_W-1:0]            stat_wr_cnt,
  output logic [STAT_W-1:0]            stat_rd_cnt
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic [BUS_DW-1:0] wdata_q;
  logic              rd_q;
  logic              bd_we_q;
  logic              bus_req;

  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [BUS_DW-1:0] ram_wdata, ram_rdata;

  logic              bus_ready_q, rdv_q, bd_ack_q, proto_err_q;
  logic [BUS_DW-1:0] rdata_q, bd_rdata_q;

  // Upper address bits alias onto the array.
  logic addr_hi_unused;
  assign addr_hi_unused = ^bus_addr[BUS_AW-1:AW];

  assign bus_req = bus_rd | bus_wr;

  sdio_bus_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk   (bus_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read is launched on the cycle that enters ACK so the byte is
  // already in the RAM output register during ACK; that lets bus_rdata be a
  // plain register while still meeting RD_LAT=1. The RAM port stays idle
  // through RLAT, so its output register holds the byte for longer latencies.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end else begin
            state_d  = ST_ACK;
            ram_en   = bus_rd;
            ram_addr = bus_addr[AW-1:0];
          end
        end else if (bd_req) begin
          state_d   = ST_BD;
          ram_en    = 1'b1;
          ram_we    = bd_we;
          ram_addr  = bd_addr;
          ram_wdata = bd_wdata;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          ram_en  = rd_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (rd_q) begin
          state_d = ST_RLAT;
          cnt_d   = 4'(RD_LAT - 1);
        end else begin
          state_d = ST_IDLE;
          ram_en  = 1'b1;
          ram_we  = 1'b1;
        end
      end
      ST_RLAT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_BD:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      bd_we_q     <= 1'b0;
      bus_ready_q <= 1'b0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
      bd_ack_q    <= 1'b0;
      bd_rdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_ready_q <= (state_d == ST_ACK);
      rdv_q       <= (state_d == ST_RLAT) && (cnt_d == 4'd0);
      bd_ack_q    <= (state_q == ST_BD);
      if (state_q == ST_IDLE) begin
        if (bus_req) begin
          addr_q  <= bus_addr[AW-1:0];
          wdata_q <= bus_wdata;
          rd_q    <= bus_rd;
          if (bus_rd && bus_wr) proto_err_q <= 1'b1;
        end else if (bd_req) begin
          bd_we_q <= bd_we;
        end
      end
      if ((state_d == ST_RLAT) && (cnt_d == 4'd0)) rdata_q <= ram_rdata;
      if ((state_q == ST_BD) && !bd_we_q)          bd_rdata_q <= ram_rdata;
    end
  end

  assign bus_ready       = bus_ready_q;
  assign bus_rdata_ready = rdv_q;
  assign bus_rdata       = rdata_q;
  assign bd_ack          = bd_ack_q;
  assign bd_rdata        = bd_rdata_q;
  assign proto_err       = proto_err_q;

`ifdef SDIO_BUS_STAT_EN
  logic [STAT_W-1:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (state_q == ST_ACK) begin
      if (rd_q) begin
        if (stat_rd_q != '1) stat_rd_q <= stat_rd_q + 1'b1;
      end else begin
        if (stat_wr_q != '1) stat_wr_q <= stat_wr_q + 1'b1;
      end
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`else
  // No access counters in this build.
`endif

endmodule
